// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for the bit-serial adder
//
// Purpose: carries the request (start, a, b, ci) and the result
// (busy, done, sum, co) between a requester and serial_adder.
// Ports (signals):
//   start        request pulse, sampled by the adder only when not busy
//   a, b [W]     operands, captured on the accepting edge
//   ci           carry-in, captured on the accepting edge
//   busy         calculation in progress
//   done         one-cycle completion pulse
//   sum [W], co  registered result, held until the next completion
// Modports: master = requester, slave = adder.

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder bit per clock, LSB first
//
// Purpose: captures a, b, ci on an accepted start, runs WIDTH cycles through
// a single full-adder cell with a registered carry, then loads sum/co and
// pulses done for one cycle. {co,sum} = a + b + ci.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts a calculation and clears sum/co
//   bus   serial_adder_if.slave (start, a, b, ci in; busy, done, sum, co out)
// Parameter: WIDTH operand/sum width, 2..32.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;

  logic             load;
  logic             finish;
  logic             fa_s;
  logic             fa_c;

  // Full-adder cell on the current LSB pair and the registered carry.
  assign fa_s = sa[0] ^ sb[0] ^ c;
  assign fa_c = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & c);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is ignored here; nothing is queued.
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A start in the completion cycle is accepted back-to-back.
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa      <= '0;
      sb      <= '0;
      ss      <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sa  <= bus.a;
        sb  <= bus.b;
        c   <= bus.ci;
        cnt <= '0;
        ss  <= '0;
      end else if (state_q == RUN) begin
        ss  <= {fa_s, ss[WIDTH-1:1]};
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        c   <= fa_c;
        cnt <= cnt + 1'b1;
        // The final bit goes straight into the result register so sum
        // is complete on the same edge that enters DONE.
        if (finish) begin
          sum_q <= {fa_s, ss[WIDTH-1:1]};
          co_q  <= fa_c;
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;

endmodule
